// File: rtl/facto_ctrl.sv
// -----------------------------------------------------------------------------
// facto_ctrl
//   Iterative factorial engine. On op_start (sampled in IDLE) the signed 64-bit
//   operand N is latched and N! is computed with one 128x64 multiply per clock.
//   The 128-bit result (wrapped modulo 2^128) is held with op_done until
//   op_clear returns the engine to IDLE.
//
//   Optional feature macro: FACTO_OVF_EN
//     When defined, adds op_ovf, a sticky flag set when any product in the run
//     exceeds 2^128-1. It is valid together with op_done.
//
// Ports
//   clk       in   1    clock, all logic on the rising edge
//   reset     in   1    synchronous active-high reset
//   op_start  in   1    level start request, sampled only in IDLE
//   op_clear  in   1    synchronous clear/abort, any state
//   oper      in   64   operand N, signed two's complement
//   op_done   out  1    result valid (DONE state)
//   result    out  128  N! truncated to 128 bits
//   op_ovf    out  1    overflow flag (FACTO_OVF_EN only)
// -----------------------------------------------------------------------------
module facto_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic         op_start,
  input  logic         op_clear,
  input  logic [63:0]  oper,
`ifdef FACTO_OVF_EN
  output logic         op_ovf,
`endif
  output logic         op_done,
  output logic [127:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [63:0]    counter, counter_nxt;
  logic [127:0]   result_nxt;

  // The counter is always >= 2 when the product is used, so an unsigned
  // multiply is correct even though the operand is signed on entry.
`ifdef FACTO_OVF_EN
  logic [191:0]   product;
  logic           ovf_nxt;
  assign product = {64'd0, result} * {128'd0, counter};
`else
  logic [127:0]   product;
  assign product = result * {64'd0, counter};
`endif

  // op_done decodes the state register directly, so it carries no
  // combinational path from any input.
  assign op_done = (state == DONE);

  // NOTE: every signal assigned here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt   = state;
    result_nxt  = result;
    counter_nxt = counter;
`ifdef FACTO_OVF_EN
    ovf_nxt     = op_ovf;
`endif

    if (op_clear) begin
      state_nxt  = IDLE;
      result_nxt = '0;
`ifdef FACTO_OVF_EN
      ovf_nxt    = 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          result_nxt = '0;
          if (op_start) begin
            result_nxt = 128'd1;
`ifdef FACTO_OVF_EN
            ovf_nxt    = 1'b0;
`endif
            // 0!, 1! and negative operands all finish immediately with 1.
            if ($signed(oper) <= 64'sd1) begin
              state_nxt = DONE;
            end else begin
              counter_nxt = oper;
              state_nxt   = BUSY;
            end
          end
        end

        BUSY: begin
          result_nxt  = product[127:0];
          counter_nxt = counter - 64'd1;
`ifdef FACTO_OVF_EN
          ovf_nxt     = op_ovf | (|product[191:128]);
`endif
          // Multiplying by 2 is the last useful step.
          if (counter == 64'd2) state_nxt = DONE;
        end

        DONE: begin
          // Hold until op_clear; op_start is deliberately ignored here.
        end

        default: begin
          state_nxt  = IDLE;
          result_nxt = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      result  <= '0;
      counter <= '0;
`ifdef FACTO_OVF_EN
      op_ovf  <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      result  <= result_nxt;
      counter <= counter_nxt;
`ifdef FACTO_OVF_EN
      op_ovf  <= ovf_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_facto_ctrl.sv
// -----------------------------------------------------------------------------
// tb_facto_ctrl
//   Self-checking bench for facto_ctrl. Expected results and latencies are
//   computed by a reference factorial model and pushed to a scoreboard when a
//   start is driven; they are popped and compared when op_done rises.
// -----------------------------------------------------------------------------
module tb_facto_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         op_start;
  logic         op_clear;
  logic [63:0]  oper;
  logic         op_done;
  logic [127:0] result;
`ifdef FACTO_OVF_EN
  logic         op_ovf;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] res;
    int           lat;
    bit           ovf;
  } exp_t;

  exp_t sb[$];

  facto_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .op_start (op_start),
    .op_clear (op_clear),
    .oper     (oper),
`ifdef FACTO_OVF_EN
    .op_ovf   (op_ovf),
`endif
    .op_done  (op_done),
    .result   (result)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: full-width product so the overflow flag is exact for N <= 57;
  // the low 128 bits are the wrapped result for any N.
  function automatic exp_t model(input logic signed [63:0] n);
    exp_t         e;
    logic [255:0] full;
    full = 256'd1;
    for (longint i = 2; i <= n; i++) full = full * 256'(i);
    e.res = full[127:0];
    e.lat = (n <= 1) ? 0 : int'(n - 1);
    e.ovf = (full[255:128] != '0);
    return e;
  endfunction

  // Drives the start edge E0; op_start stays high until the caller drops it.
  task automatic start_op(input logic signed [63:0] n, input bit push);
    oper     = n;
    op_start = 1'b1;
    if (push) sb.push_back(model(n));
    tick();
  endtask

  task automatic await_done(input string tag);
    int   cycles;
    exp_t e;
    cycles = 0;
    while (!op_done && cycles < 200) begin
      tick();
      cycles++;
    end
    check({tag, "_done"}, op_done, 1);
    check({tag, "_sb"}, (sb.size() != 0), 1);
    if (op_done && sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_lat"}, cycles, e.lat);
      check({tag, "_res"}, result, e.res);
`ifdef FACTO_OVF_EN
      check({tag, "_ovf"}, op_ovf, e.ovf);
`endif
    end
  endtask

  task automatic clear_op();
    op_start = 1'b0;
    op_clear = 1'b1;
    tick();
    op_clear = 1'b0;
  endtask

  initial begin
    bit seen;
    logic signed [63:0] vals [3];

    reset    = 1'b1;
    op_start = 1'b0;
    op_clear = 1'b0;
    oper     = '0;
    tick();
    tick();
    check("rst_done", op_done, 0);
    check("rst_res", result, 0);
    reset = 1'b0;
    repeat (5) tick();
    check("idle_done", op_done, 0);
    check("idle_res", result, 0);

    // 7! with op_start held high through DONE.
    start_op(64'sd7, 1'b1);
    await_done("f7");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("f7_hold_done", op_done, 1);
      check("f7_hold_res", result, 128'd5040);
    end
    clear_op();
    check("f7_clr_done", op_done, 0);
    check("f7_clr_res", result, 0);
    tick();
    check("f7_idle_done", op_done, 0);

    // Operands that finish at E0.
    vals = '{64'sd0, 64'sd1, -64'sd5};
    foreach (vals[k]) begin
      start_op(vals[k], 1'b1);
      op_start = 1'b0;
      await_done("small");
      clear_op();
    end

    // 20! against the model and a known constant.
    start_op(64'sd20, 1'b1);
    op_start = 1'b0;
    await_done("f20");
    check("f20_const", result, 128'd2432902008176640000);
    clear_op();

    // Abort mid-run; a changed oper must not matter and no done may follow.
    start_op(64'sd20, 1'b0);
    op_start = 1'b0;
    oper     = 64'd3;
    repeat (4) tick();
    check("abort_busy", op_done, 0);
    op_clear = 1'b1;
    tick();
    op_clear = 1'b0;
    check("abort_done", op_done, 0);
    check("abort_res", result, 0);
    seen = 1'b0;
    repeat (30) begin
      tick();
      if (op_done) seen = 1'b1;
    end
    check("abort_nodone", seen, 0);

    // op_clear wins over a held op_start, which then restarts from IDLE.
    start_op(64'sd2, 1'b1);
    await_done("f2");
    oper     = 64'd3;
    op_clear = 1'b1;
    tick();
    op_clear = 1'b0;
    check("restart_clr_done", op_done, 0);
    check("restart_clr_res", result, 0);
    sb.push_back(model(64'sd3));
    tick();
    await_done("restart");
    clear_op();

    // A few random operands.
    for (int r = 0; r < 4; r++) begin
      start_op(64'($urandom_range(2, 30)), 1'b1);
      op_start = 1'b0;
      await_done("rand");
      clear_op();
    end

`ifdef FACTO_OVF_EN
    start_op(64'sd34, 1'b1);
    op_start = 1'b0;
    await_done("f34");
    check("f34_ovf", op_ovf, 0);
    clear_op();
    start_op(64'sd35, 1'b1);
    op_start = 1'b0;
    await_done("f35");
    check("f35_ovf", op_ovf, 1);
    clear_op();
    check("f35_clr_ovf", op_ovf, 0);
`else
    // Wrap-around without the overflow feature: 35! mod 2^128.
    start_op(64'sd35, 1'b1);
    op_start = 1'b0;
    await_done("f35");
    clear_op();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
